// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Round-robin on ties, fixed RAM read latency, one-cycle ready pulses.
module mem_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {G_FETCH, G_DATA} grant_t;

  state_t              state_q, state_d;
  grant_t              last_q, last_d;
  grant_t              port_q, port_d;
  grant_t              pick;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_req;

  assign d_req = d_ren | d_wen;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      last_q    <= G_DATA;
      port_q    <= G_FETCH;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      port_q    <= port_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    port_d    = port_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick      = G_FETCH;
    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) pick = (last_q == G_DATA) ? G_FETCH : G_DATA;
          else                pick = i_req ? G_FETCH : G_DATA;
          port_d  = pick;
          last_d  = pick;
          state_d = S_ISSUE;
          if (pick == G_FETCH) begin
            addr_d = i_addr;
            wr_d   = 1'b0;
          end else begin
            addr_d  = d_addr;
            wr_d    = d_wen;   // ren+wen together is a plain write
            wdata_d = d_wdata;
          end
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(RAM_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (port_q == G_FETCH) i_rdata_d = ram_rdata;
          else                   d_rdata_d = ram_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_ren   = (state_q == S_ISSUE) && !wr_q;
  assign ram_wen   = (state_q == S_ISSUE) &&  wr_q;
  assign i_ready   = (state_q == S_DONE) && (port_q == G_FETCH);
  assign d_ready   = (state_q == S_DONE) && (port_q == G_DATA);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule
